// File: rtl/fb_scan_reader.sv
// Frame buffer read-side scan engine: fetches each row's 32-bit words from the RAM,
// shifts them MSB-first into the LED driver chain, then blanks, latches and selects the row.
module fb_scan_reader #(
    parameter int ROW_W    = 3,
    parameter int WORD_W   = 6,
    parameter int CLK_DIV  = 1,
    parameter int HOLD_CYC = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    output logic [ROW_W+WORD_W-1:0] addr_o,
    input  logic [31:0]             data_i,
    output logic                    sclk_o,
    output logic                    sdata_o,
    output logic                    latch_o,
    output logic                    oe_n_o,
    output logic [ROW_W-1:0]        row_o,
    output logic                    frame_done_o
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [ROW_W-1:0]  LAST_ROW  = {ROW_W{1'b1}};
    localparam logic [WORD_W-1:0] LAST_WORD = {WORD_W{1'b1}};
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_BLANK = 3'd4,
        S_LATCH = 3'd5
    } state_t;

    state_t                    r_state;
    logic                      r_fetch_ph;
    logic [ROW_W-1:0]          r_row_ptr;
    logic [WORD_W-1:0]         r_word_ptr;
    logic [4:0]                r_bit_cnt;
    logic [DIV_W-1:0]          r_div_cnt;
    logic [30:0]               r_shreg;
    logic [HOLD_W-1:0]         r_hold_cnt;
    logic                      r_first;
    logic [ROW_W+WORD_W-1:0]   r_addr;
    logic                      r_sclk;
    logic                      r_sdata;
    logic                      r_latch;
    logic                      r_oe_n;
    logic [ROW_W-1:0]          r_row;
    logic                      r_frame_done;

    state_t                    w_state_nxt;
    logic                      w_fetch_ph_nxt;
    logic [ROW_W-1:0]          w_row_ptr_nxt;
    logic [WORD_W-1:0]         w_word_ptr_nxt;
    logic [4:0]                w_bit_cnt_nxt;
    logic [DIV_W-1:0]          w_div_cnt_nxt;
    logic [30:0]               w_shreg_nxt;
    logic [HOLD_W-1:0]         w_hold_cnt_nxt;
    logic                      w_first_nxt;
    logic [ROW_W+WORD_W-1:0]   w_addr_nxt;
    logic                      w_sclk_nxt;
    logic                      w_sdata_nxt;
    logic                      w_latch_nxt;
    logic                      w_oe_n_nxt;
    logic [ROW_W-1:0]          w_row_nxt;
    logic                      w_frame_done_nxt;

    logic [ROW_W-1:0]          w_row_inc;
    logic [WORD_W-1:0]         w_word_inc;

    assign w_row_inc  = r_row_ptr + ROW_W'(1);
    assign w_word_inc = r_word_ptr + WORD_W'(1);

    // Next-state and next-output logic for the scan sequencer
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_ph_nxt   = r_fetch_ph;
        w_row_ptr_nxt    = r_row_ptr;
        w_word_ptr_nxt   = r_word_ptr;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_div_cnt_nxt    = r_div_cnt;
        w_shreg_nxt      = r_shreg;
        w_first_nxt      = r_first;
        w_addr_nxt       = r_addr;
        w_sclk_nxt       = r_sclk;
        w_sdata_nxt      = r_sdata;
        w_latch_nxt      = 1'b0;
        w_oe_n_nxt       = r_oe_n;
        w_row_nxt        = r_row;
        w_frame_done_nxt = 1'b0;
        // Hold counter measures display time since the last latch and saturates
        w_hold_cnt_nxt   = (r_hold_cnt == HOLD_SAT) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);

        if (!enable_i) begin
            w_state_nxt    = S_IDLE;
            w_fetch_ph_nxt = 1'b0;
            w_row_ptr_nxt  = '0;
            w_word_ptr_nxt = '0;
            w_bit_cnt_nxt  = 5'd0;
            w_div_cnt_nxt  = '0;
            w_shreg_nxt    = 31'd0;
            w_hold_cnt_nxt = '0;
            w_first_nxt    = 1'b1;
            w_addr_nxt     = '0;
            w_sclk_nxt     = 1'b0;
            w_sdata_nxt    = 1'b0;
            w_oe_n_nxt     = 1'b1;
            w_row_nxt      = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt    = S_FETCH;
                    w_fetch_ph_nxt = 1'b0;
                    w_word_ptr_nxt = '0;
                    w_first_nxt    = 1'b1;
                    w_addr_nxt     = {r_row_ptr, WORD_W'(0)};
                end
                S_FETCH: begin
                    // First cycle lets the RAM register the address; second samples its data
                    if (!r_fetch_ph) begin
                        w_fetch_ph_nxt = 1'b1;
                    end else begin
                        w_fetch_ph_nxt = 1'b0;
                        w_shreg_nxt    = data_i[30:0];
                        w_sdata_nxt    = data_i[31];
                        w_bit_cnt_nxt  = 5'd0;
                        w_div_cnt_nxt  = '0;
                        w_sclk_nxt     = 1'b0;
                        w_state_nxt    = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_div_cnt != DIV_LAST) begin
                        w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
                    end else if (!r_sclk) begin
                        w_div_cnt_nxt = '0;
                        w_sclk_nxt    = 1'b1;
                    end else begin
                        w_div_cnt_nxt = '0;
                        w_sclk_nxt    = 1'b0;
                        if (r_bit_cnt != 5'd31) begin
                            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                            w_sdata_nxt   = r_shreg[30];
                            w_shreg_nxt   = {r_shreg[29:0], 1'b0};
                        end else if (r_word_ptr != LAST_WORD) begin
                            w_word_ptr_nxt = w_word_inc;
                            w_addr_nxt     = {r_row_ptr, w_word_inc};
                            w_state_nxt    = S_FETCH;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Exit one cycle early so BLANK lands exactly HOLD_CYC after LATCH
                    if (r_first || (r_hold_cnt >= HOLD_LAST)) begin
                        w_oe_n_nxt  = 1'b1;
                        w_state_nxt = S_BLANK;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_BLANK: begin
                    w_latch_nxt      = 1'b1;
                    w_row_nxt        = r_row_ptr;
                    w_frame_done_nxt = (r_row_ptr == LAST_ROW);
                    w_hold_cnt_nxt   = '0;
                    w_state_nxt      = S_LATCH;
                end
                S_LATCH: begin
                    w_oe_n_nxt     = 1'b0;
                    w_first_nxt    = 1'b0;
                    w_row_ptr_nxt  = w_row_inc;
                    w_word_ptr_nxt = '0;
                    w_addr_nxt     = {w_row_inc, WORD_W'(0)};
                    w_fetch_ph_nxt = 1'b0;
                    w_state_nxt    = S_FETCH;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_oe_n_nxt  = 1'b1;
                    w_sclk_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_ph   <= 1'b0;
            r_row_ptr    <= '0;
            r_word_ptr   <= '0;
            r_bit_cnt    <= 5'd0;
            r_div_cnt    <= '0;
            r_shreg      <= 31'd0;
            r_hold_cnt   <= '0;
            r_first      <= 1'b1;
            r_addr       <= '0;
            r_sclk       <= 1'b0;
            r_sdata      <= 1'b0;
            r_latch      <= 1'b0;
            r_oe_n       <= 1'b1;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_fetch_ph   <= w_fetch_ph_nxt;
            r_row_ptr    <= w_row_ptr_nxt;
            r_word_ptr   <= w_word_ptr_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_first      <= w_first_nxt;
            r_addr       <= w_addr_nxt;
            r_sclk       <= w_sclk_nxt;
            r_sdata      <= w_sdata_nxt;
            r_latch      <= w_latch_nxt;
            r_oe_n       <= w_oe_n_nxt;
            r_row        <= w_row_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign addr_o       = r_addr;
    assign sclk_o       = r_sclk;
    assign sdata_o      = r_sdata;
    assign latch_o      = r_latch;
    assign oe_n_o       = r_oe_n;
    assign row_o        = r_row;
    assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Scoreboard bench for fb_scan_reader: a schedule model predicts every latch (cycle, row,
// frame_done, shifted stream); a monitor captures the serial stream and compares.
module tb_fb_scan_reader;

    localparam int ROW_W    = 1;
    localparam int WORD_W   = 1;
    localparam int CLK_DIV  = 2;
    localparam int HOLD_CYC = 300;
    localparam int NR       = 1 << ROW_W;
    localparam int NW       = 1 << WORD_W;
    localparam int NB       = NW * 32;
    localparam int WT       = 2 + 64 * CLK_DIV;

    logic                    clk = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    enable_i = 1'b0;
    logic [ROW_W+WORD_W-1:0] addr_o;
    logic [ROW_W+WORD_W-1:0] ram_addr = '0;
    logic [31:0]             data_i;
    logic                    sclk_o, sdata_o, latch_o, oe_n_o, frame_done_o;
    logic [ROW_W-1:0]        row_o;

    logic [31:0] mem [NR*NW];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        en_seen = 1'b0;

    typedef struct {
        int              cyc;
        int              row;
        bit              fd;
        logic [NB-1:0]   bits;
    } exp_t;
    exp_t sb[$];

    fb_scan_reader #(
        .ROW_W(ROW_W), .WORD_W(WORD_W), .CLK_DIV(CLK_DIV), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .addr_o(addr_o),
        .data_i(data_i), .sclk_o(sclk_o), .sdata_o(sdata_o), .latch_o(latch_o),
        .oe_n_o(oe_n_o), .row_o(row_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    // RAM model: registered address, combinational read
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        en_seen  <= enable_i;
        ram_addr <= addr_o;
    end
    assign data_i = mem[ram_addr];

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: capture bits on sclk rises, check waveform shape, pop scoreboard on latch
    bit   cap[$];
    logic prev_sclk = 1'b0;
    logic prev_sdata = 1'b0;
    int   hi_run = 0;
    bit   post_latch = 1'b0;
    exp_t m_e;
    logic [NB-1:0] got;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_ni || !en_seen) begin
                cap.delete();
                hi_run = 0;
                post_latch = 1'b0;
            end else begin
                if (post_latch) chk("oe_after_latch", NB'(oe_n_o), NB'(0));
                post_latch = 1'b0;
                if (sclk_o) chk("sdata_stable_high", NB'(sdata_o), NB'(prev_sdata));
                if (sclk_o && !prev_sclk) cap.push_back(sdata_o);
                if (sclk_o) hi_run++;
                else if (prev_sclk) begin
                    chk("sclk_high_len", NB'(hi_run), NB'(CLK_DIV));
                    hi_run = 0;
                end
                chk("fd_only_with_latch", NB'(frame_done_o & ~latch_o), NB'(0));
                if (latch_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_latch", NB'(1), NB'(0));
                    end else begin
                        m_e = sb.pop_front();
                        got = '0;
                        for (int i = 0; i < cap.size() && i < NB; i++) got[NB-1-i] = cap[i];
                        chk("latch_cycle", NB'(cyc), NB'(m_e.cyc));
                        chk("row_o", NB'(row_o), NB'(m_e.row));
                        chk("frame_done", NB'(frame_done_o), NB'(m_e.fd));
                        chk("oe_blank_at_latch", NB'(oe_n_o), NB'(1));
                        chk("bit_count", NB'(cap.size()), NB'(NB));
                        chk("stream", got, m_e.bits);
                    end
                    cap.delete();
                    post_latch = 1'b1;
                end
            end
            prev_sclk  = sclk_o;
            prev_sdata = sdata_o;
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_oe_n"}, NB'(oe_n_o), NB'(1));
        chk({tag, "_sclk"}, NB'(sclk_o), NB'(0));
        chk({tag, "_sdata"}, NB'(sdata_o), NB'(0));
        chk({tag, "_latch"}, NB'(latch_o), NB'(0));
        chk({tag, "_row"}, NB'(row_o), NB'(0));
        chk({tag, "_fd"}, NB'(frame_done_o), NB'(0));
        chk({tag, "_addr"}, NB'(addr_o), NB'(0));
    endtask

    // One enabled run of len cycles, ended by enable drop or an async reset between edges
    task automatic run(input int len, input bit use_rst);
        int   e0, cut, lat, row, nxt_a, nxt_b;
        exp_t e;
        @(negedge clk);
        enable_i = 1'b1;
        e0  = cyc + 1;
        cut = e0 + len;
        lat = e0 + NW * WT + 2;
        row = 0;
        while (lat <= cut) begin
            e.cyc = lat;
            e.row = row;
            e.fd  = (row == NR - 1);
            for (int w = 0; w < NW; w++) e.bits[NB-1-32*w -: 32] = mem[row*NW + w];
            sb.push_back(e);
            nxt_a = lat + NW * WT + 3;
            nxt_b = lat + HOLD_CYC + 1;
            lat   = (nxt_a > nxt_b) ? nxt_a : nxt_b;
            row   = (row + 1) % NR;
        end
        @(negedge clk);
        chk("first_addr", NB'(addr_o), NB'(0));
        while (cyc < cut) @(negedge clk);
        if (use_rst) begin
            #2 rst_ni = 1'b0;
            #1 chk_idle_outputs("async_rst");
            enable_i = 1'b0;
            @(negedge clk);
            rst_ni = 1'b1;
        end else begin
            enable_i = 1'b0;
            @(negedge clk);
            chk_idle_outputs("disable");
        end
        repeat (6) @(negedge clk);
        chk("all_latches_seen", NB'(sb.size()), NB'(0));
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d latches pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'hA500_0001;
        mem[1] = 32'h0000_FFFF;
        mem[2] = 32'h8000_0000;
        mem[3] = 32'h0000_0001;
        @(negedge clk);
        chk_idle_outputs("reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        run(900, 1'b0);
        run(WT + 2 + 2 * CLK_DIV * 21 + 1, 1'b0);
        run(60, 1'b1);
        run(900, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NR * NW; i++) mem[i] = $urandom;
            run(int'($urandom_range(100, 1400)), 1'($urandom_range(0, 1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
